jpeg_rle: RTL and testbench

JPEG_RLE -- requirements
Module: jpeg_rle

---
 rtl/jpeg_rle.sv | 164 ++++++++++++++++
 tb/tb_jpeg_rle.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle.sv
// JPEG zero-run / magnitude-category encoder for 8-coefficient zigzag beats.
// Define JPEG_RLE_DC_DIFF_EN to code DC as the difference from the previous block DC.
module jpeg_rle #(
    parameter int BW = 8
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [3:0]      o_run,
    output logic [3:0]      o_size,
    output logic [BW:0]     o_amp,
    output logic            o_dc,
    output logic            o_eob
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_ZRL  = 2'd2;
    localparam logic [1:0] S_EOB  = 2'd3;

    logic [1:0]           state;
    logic [8*BW-1:0]      hold;
    logic [2:0]           slot;
    logic [2:0]           beat;
    logic [5:0]           run;
    logic signed [BW-1:0] coef;
    logic signed [BW:0]   val;
    logic [BW:0]          mag;
    logic [BW:0]          amp_raw;
    logic [BW:0]          mask;
    logic [BW:0]          amp;
    logic [3:0]           size;
    logic                 is_dc;
    logic                 advance;
    logic [1:0]           step_state;

    assign coef    = hold[(7 - int'(slot)) * BW +: BW];
    assign is_dc   = (beat == 3'd0) && (slot == 3'd0);
    assign advance = !o_valid || i_ready;
    assign o_ready = (state == S_IDLE);

`ifdef JPEG_RLE_DC_DIFF_EN
    logic signed [BW-1:0] pred;
    assign val = is_dc ? ({coef[BW-1], coef} - {pred[BW-1], pred})
                       : {coef[BW-1], coef};
`else
    assign val = {coef[BW-1], coef};
`endif

    // The difference range never reaches -2^BW, so negation cannot overflow.
    assign mag     = val[BW] ? -val : val;
    assign amp_raw = val[BW] ? val - 1'b1 : val;

    always_comb begin
        size = 4'd0;
        for (int i = 0; i <= BW; i++)
            if (mag[i]) size = 4'(i + 1);
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i <= BW; i++)
            mask[i] = (i < int'(size));
    end

    assign amp = amp_raw & mask;

    // A zero coefficient 63 always leaves a pending run, which needs an EOB.
    always_comb begin
        step_state = S_SCAN;
        if (slot == 3'd7)
            step_state = (beat == 3'd7 && coef == '0) ? S_EOB : S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_Reset) begin
            state   <= S_IDLE;
            hold    <= '0;
            slot    <= '0;
            beat    <= '0;
            run     <= '0;
            o_valid <= 1'b0;
            o_run   <= '0;
            o_size  <= '0;
            o_amp   <= '0;
            o_dc    <= 1'b0;
            o_eob   <= 1'b0;
`ifdef JPEG_RLE_DC_DIFF_EN
            pred    <= '0;
`endif
        end else begin
            if (o_valid && i_ready)
                o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        hold  <= i_data;
                        slot  <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN, S_ZRL: begin
                    if (advance) begin
                        if (is_dc) begin
                            o_valid <= 1'b1;
                            o_run   <= 4'd0;
                            o_size  <= size;
                            o_amp   <= amp;
                            o_dc    <= 1'b1;
                            o_eob   <= 1'b0;
`ifdef JPEG_RLE_DC_DIFF_EN
                            pred    <= coef;
`endif
                            slot    <= slot + 3'd1;
                            state   <= step_state;
                        end else if (coef == '0) begin
                            run   <= run + 6'd1;
                            slot  <= slot + 3'd1;
                            state <= step_state;
                            if (slot == 3'd7) beat <= beat + 3'd1;
                        end else if (run >= 6'd16) begin
                            o_valid <= 1'b1;
                            o_run   <= 4'd15;
                            o_size  <= 4'd0;
                            o_amp   <= '0;
                            o_dc    <= 1'b0;
                            o_eob   <= 1'b0;
                            run     <= run - 6'd16;
                            state   <= S_ZRL;
                        end else begin
                            o_valid <= 1'b1;
                            o_run   <= run[3:0];
                            o_size  <= size;
                            o_amp   <= amp;
                            o_dc    <= 1'b0;
                            o_eob   <= 1'b0;
                            run     <= '0;
                            slot    <= slot + 3'd1;
                            state   <= step_state;
                            if (slot == 3'd7) beat <= beat + 3'd1;
                        end
                    end
                end
                default: begin
                    if (advance) begin
                        o_valid <= 1'b1;
                        o_run   <= 4'd0;
                        o_size  <= 4'd0;
                        o_amp   <= '0;
                        o_dc    <= 1'b0;
                        o_eob   <= 1'b1;
                        run     <= '0;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_rle.sv
// Directed-vector bench for jpeg_rle: symbol streams checked against hand-coded tables.
module tb_jpeg_rle;

    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            i_Reset;
    logic [8*BW-1:0] i_data;
    logic            i_valid;
    logic            o_ready;
    logic            o_valid;
    logic            i_ready;
    logic [3:0]      o_run;
    logic [3:0]      o_size;
    logic [BW:0]     o_amp;
    logic            o_dc;
    logic            o_eob;

    int n_vec = 0;
    int n_err = 0;
    logic [21:0] got_q[$];
    logic [21:0] exp_q[$];
    logic signed [BW-1:0] blk[64];
    logic bp_en = 1'b0;

    always #5 clk = ~clk;

    jpeg_rle #(.BW(BW)) dut (
        .i_clk   (clk),
        .i_Reset (i_Reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_run   (o_run),
        .o_size  (o_size),
        .o_amp   (o_amp),
        .o_dc    (o_dc),
        .o_eob   (o_eob)
    );

    function automatic logic [21:0] sym(input logic dc, input logic eob,
                                        input logic [3:0] run, input logic [3:0] size,
                                        input logic [11:0] amp);
        return {dc, eob, run, size, amp};
    endfunction

    function automatic logic [21:0] cur_sym();
        return sym(o_dc, o_eob, o_run, o_size, 12'(o_amp));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (i_Reset && o_valid && i_ready)
            got_q.push_back(cur_sym());

    always begin
        @(posedge clk);
        #1;
        if (bp_en) i_ready = ~i_ready;
    end

    task automatic clear_blk();
        foreach (blk[i]) blk[i] = '0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        i_Reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_Reset = 1'b1;
    endtask

    task automatic send_beat(input int b);
        int t = 0;
        while (!o_ready && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
        for (int s = 0; s < 8; s++)
            i_data[(7 - s) * BW +: BW] = blk[b * 8 + s];
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_block();
        for (int b = 0; b < 8; b++) send_beat(b);
    endtask

    task automatic expect_syms(input string name);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (20) @(posedge clk);
        #1;
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size())
                check($sformatf("%s_sym%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
            else
                check($sformatf("%s_sym%0d_missing", name, i), 32'h3fffff, 32'(exp_q[i]));
        end
    endtask

    task automatic stall_watch();
        logic [21:0] snap;
        int t = 0;
        while (!o_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("stall_valid", 32'(o_valid), 32'd1);
        snap = cur_sym();
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_hold", 32'(cur_sym()), 32'(snap));
            check("stall_vld", 32'(o_valid), 32'd1);
            check("stall_rdy", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
    endtask

    initial begin
        i_Reset = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_fields", 32'(cur_sym()), 32'd0);
        i_Reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid2", 32'(o_valid), 32'd0);

        // all-zero block
        clear_blk();
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        send_block();
        expect_syms("zero");

        // DC 5, AC1 -3, with alternating backpressure
        clear_blk();
        blk[0] = 8'sd5;
        blk[1] = -8'sd3;
        exp_q.push_back(sym(1, 0, 0, 3, 12'h5));
        exp_q.push_back(sym(0, 0, 0, 2, 12'h0));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        bp_en = 1'b1;
        send_block();
        expect_syms("dc5");
        bp_en = 1'b0;
        i_ready = 1'b1;

        // index 20 = 1, with a 5-cycle stall on the DC symbol
        do_reset();
        clear_blk();
        blk[20] = 8'sd1;
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 3, 1, 12'h1));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        i_ready = 1'b0;
        fork
            send_block();
            stall_watch();
        join
        expect_syms("zrl1");

        // index 63 = 7: three ZRLs, no EOB
        do_reset();
        clear_blk();
        blk[63] = 8'sd7;
        exp_q.push_back(sym(1, 0, 0, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 15, 0, 0));
        exp_q.push_back(sym(0, 0, 14, 3, 12'h7));
        send_block();
        expect_syms("last63");

        // two blocks, DC 10 then 7
        do_reset();
        clear_blk();
        blk[0] = 8'sd10;
        exp_q.push_back(sym(1, 0, 0, 4, 12'ha));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        send_block();
        blk[0] = 8'sd7;
`ifdef JPEG_RLE_DC_DIFF_EN
        exp_q.push_back(sym(1, 0, 0, 2, 12'h0));
`else
        exp_q.push_back(sym(1, 0, 0, 3, 12'h7));
`endif
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        send_block();
        expect_syms("dc2blk");

        // reset in the middle of a block, then a fresh block
        do_reset();
        clear_blk();
        blk[0] = 8'sd3;
        blk[9] = 8'sd4;
        for (int b = 0; b < 3; b++) send_beat(b);
        do_reset();
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        clear_blk();
        blk[0]  = -8'sd1;
        blk[2]  = 8'sd100;
        blk[10] = -8'sd128;
        exp_q.push_back(sym(1, 0, 0, 1, 12'h0));
        exp_q.push_back(sym(0, 0, 1, 7, 12'h64));
        exp_q.push_back(sym(0, 0, 7, 8, 12'h7f));
        exp_q.push_back(sym(0, 1, 0, 0, 0));
        send_block();
        expect_syms("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
